// File: rtl/store_stage.sv
// store_stage: final pipeline stage. Retires execute-stage packets by
// performing register writes, lane-serial memory loads/stores, fetch
// redirects and halt.
//
//   state         | meaning
//   --------------+------------------------------------------------------
//   ST_IDLE       | ready for a packet; one-cycle ops retire from here
//   ST_MEM_REQ    | request for current lane presented, waiting for ready
//   ST_MEM_WAIT   | load issued for current lane, waiting for response
//   ST_WRITEBACK  | load result (rf write or PC redirect) pulsing
//   ST_HALTED     | HALT retired; nothing accepted until reset
module store_stage #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 64,
  parameter int REG_ID_W  = 5,
  parameter int REG_PC_ID = 31
) (
  input  logic                          clk,
  input  logic                          reset_n,

  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_op,
  input  logic [NUM_LANES-1:0]          in_exec_mask,
  input  logic [DATA_W-1:0]             in_pc,
  input  logic [REG_ID_W-1:0]           in_reg_id,
  input  logic [NUM_LANES*DATA_W-1:0]   in_vec_a,
  input  logic [NUM_LANES*DATA_W-1:0]   in_vec_b,
  input  logic [DATA_W-1:0]             in_target0,
  input  logic [DATA_W-1:0]             in_target1,
  input  logic [NUM_LANES-1:0]          in_mask0,
  input  logic [NUM_LANES-1:0]          in_mask1,

  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_write,
  output logic [DATA_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_W-1:0]             mem_rsp_data,

  output logic                          rf_we,
  output logic [REG_ID_W-1:0]           rf_reg_id,
  output logic [NUM_LANES-1:0]          rf_lane_mask,
  output logic [NUM_LANES*DATA_W-1:0]   rf_wdata,

  output logic                          br_valid,
  output logic                          br_two_way,
  output logic [DATA_W-1:0]             br_target0,
  output logic [DATA_W-1:0]             br_target1,
  output logic [NUM_LANES-1:0]          br_mask0,
  output logic [NUM_LANES-1:0]          br_mask1,

  output logic                          halted,
  output logic                          err_bad_op
);

  localparam int VEC_W  = NUM_LANES * DATA_W;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [2:0] OP_HALT   = 3'd0;
  localparam logic [2:0] OP_JMP    = 3'd1;
  localparam logic [2:0] OP_CJMP   = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_STORE  = 3'd4;
  localparam logic [2:0] OP_SETREG = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_WRITEBACK,
    ST_HALTED
  } state_e;

  state_e                 state_q;
  logic                   is_load_q;
  logic [REG_ID_W-1:0]    reg_id_q;
  logic [NUM_LANES-1:0]   mask_q;
  logic [VEC_W-1:0]       vec_a_q;
  logic [VEC_W-1:0]       vec_b_q;
  logic [NUM_LANES-1:0]   rem_q;
  logic [LANE_W-1:0]      lane_q;
  logic [VEC_W-1:0]       buf_q;

  logic                   rf_we_q;
  logic [REG_ID_W-1:0]    rf_reg_id_q;
  logic [NUM_LANES-1:0]   rf_lane_mask_q;
  logic [VEC_W-1:0]       rf_wdata_q;

  logic                   br_valid_q;
  logic                   br_two_way_q;
  logic [DATA_W-1:0]      br_target0_q;
  logic [DATA_W-1:0]      br_target1_q;
  logic [NUM_LANES-1:0]   br_mask0_q;
  logic [NUM_LANES-1:0]   br_mask1_q;

  logic                   halted_q;
  logic                   err_q;

  logic [DATA_W-1:0]      cur_addr;
  logic [DATA_W-1:0]      cur_wdata;
  logic [VEC_W-1:0]       buf_d;
  logic [NUM_LANES-1:0]   rem_d;
  logic [LANE_W-1:0]      first_lane;
  logic [DATA_W-1:0]      pc_target;

  // The PC travels with the packet but retirement never needs it.
  logic unused_pc;
  assign unused_pc = ^in_pc;

  function automatic logic [LANE_W-1:0] low_lane(input logic [NUM_LANES-1:0] m);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i]) idx = LANE_W'(i);
    end
    return idx;
  endfunction

  // Current-lane operand select, lane retirement and load-buffer merge.
  always_comb begin
    cur_addr   = '0;
    cur_wdata  = '0;
    buf_d      = buf_q;
    rem_d      = rem_q;
    pc_target  = '0;
    first_lane = low_lane(mask_q);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        cur_addr                   = vec_a_q[i*DATA_W +: DATA_W];
        cur_wdata                  = vec_b_q[i*DATA_W +: DATA_W];
        buf_d[i*DATA_W +: DATA_W]  = mem_rsp_data;
        rem_d[i]                   = 1'b0;
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (first_lane == LANE_W'(i)) pc_target = buf_d[i*DATA_W +: DATA_W];
    end
  end

  // Packet capture, lane sequencing and registered side-effect outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      is_load_q      <= 1'b0;
      reg_id_q       <= '0;
      mask_q         <= '0;
      vec_a_q        <= '0;
      vec_b_q        <= '0;
      rem_q          <= '0;
      lane_q         <= '0;
      buf_q          <= '0;
      rf_we_q        <= 1'b0;
      rf_reg_id_q    <= '0;
      rf_lane_mask_q <= '0;
      rf_wdata_q     <= '0;
      br_valid_q     <= 1'b0;
      br_two_way_q   <= 1'b0;
      br_target0_q   <= '0;
      br_target1_q   <= '0;
      br_mask0_q     <= '0;
      br_mask1_q     <= '0;
      halted_q       <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      rf_we_q    <= 1'b0;
      br_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            is_load_q <= (in_op == OP_LOAD);
            reg_id_q  <= in_reg_id;
            mask_q    <= in_exec_mask;
            vec_a_q   <= in_vec_a;
            vec_b_q   <= in_vec_b;
            rem_q     <= in_exec_mask;
            lane_q    <= low_lane(in_exec_mask);
            buf_q     <= '0;
            case (in_op)
              OP_HALT: begin
                state_q  <= ST_HALTED;
                halted_q <= 1'b1;
              end
              OP_JMP: begin
                br_valid_q   <= 1'b1;
                br_two_way_q <= 1'b0;
                br_target0_q <= in_target0;
                br_target1_q <= '0;
                br_mask0_q   <= in_exec_mask;
                br_mask1_q   <= '0;
              end
              OP_CJMP: begin
                br_valid_q   <= 1'b1;
                br_two_way_q <= 1'b1;
                br_target0_q <= in_target0;
                br_target1_q <= in_target1;
                br_mask0_q   <= in_mask0;
                br_mask1_q   <= in_mask1;
              end
              OP_LOAD, OP_STORE: begin
                // An empty mask retires here with no memory traffic.
                if (|in_exec_mask) state_q <= ST_MEM_REQ;
              end
              OP_SETREG: begin
                if (|in_exec_mask) begin
                  rf_we_q        <= 1'b1;
                  rf_reg_id_q    <= in_reg_id;
                  rf_lane_mask_q <= in_exec_mask;
                  rf_wdata_q     <= in_vec_a;
                end
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        ST_MEM_REQ: begin
          if (mem_req_ready) begin
            if (is_load_q) begin
              state_q <= ST_MEM_WAIT;
            end else begin
              rem_q  <= rem_d;
              lane_q <= low_lane(rem_d);
              if (rem_d == '0) state_q <= ST_IDLE;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_rsp_valid) begin
            buf_q  <= buf_d;
            rem_q  <= rem_d;
            lane_q <= low_lane(rem_d);
            if (rem_d != '0) begin
              state_q <= ST_MEM_REQ;
            end else begin
              state_q <= ST_WRITEBACK;
              // A load into the PC register becomes a redirect instead.
              if (reg_id_q == REG_ID_W'(REG_PC_ID)) begin
                br_valid_q   <= 1'b1;
                br_two_way_q <= 1'b0;
                br_target0_q <= pc_target;
                br_target1_q <= '0;
                br_mask0_q   <= mask_q;
                br_mask1_q   <= '0;
              end else begin
                rf_we_q        <= 1'b1;
                rf_reg_id_q    <= reg_id_q;
                rf_lane_mask_q <= mask_q;
                rf_wdata_q     <= buf_d;
              end
            end
          end
        end
        ST_WRITEBACK: state_q <= ST_IDLE;
        ST_HALTED:    state_q <= ST_HALTED;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign mem_req_valid = (state_q == ST_MEM_REQ);
  assign mem_req_write = mem_req_valid & ~is_load_q;
  assign mem_req_addr  = cur_addr;
  assign mem_req_wdata = cur_wdata;

  assign rf_we         = rf_we_q;
  assign rf_reg_id     = rf_reg_id_q;
  assign rf_lane_mask  = rf_lane_mask_q;
  assign rf_wdata      = rf_wdata_q;

  assign br_valid      = br_valid_q;
  assign br_two_way    = br_two_way_q;
  assign br_target0    = br_target0_q;
  assign br_target1    = br_target1_q;
  assign br_mask0      = br_mask0_q;
  assign br_mask1      = br_mask1_q;

  assign halted        = halted_q;
  assign err_bad_op    = err_q;

endmodule

// File: tb/tb_store_stage.sv
// tb_store_stage: directed and random packets against a transaction-level
// model of the store stage's architectural side effects.
module tb_store_stage;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int VW = NL * DW;
  localparam logic [DW-1:0] MEM_KEY = 64'h5A5A_0F0F_C3C3_1234;

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [NL-1:0]   in_exec_mask;
  logic [DW-1:0]   in_pc;
  logic [RW-1:0]   in_reg_id;
  logic [VW-1:0]   in_vec_a;
  logic [VW-1:0]   in_vec_b;
  logic [DW-1:0]   in_target0;
  logic [DW-1:0]   in_target1;
  logic [NL-1:0]   in_mask0;
  logic [NL-1:0]   in_mask1;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_write;
  logic [DW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic            rf_we;
  logic [RW-1:0]   rf_reg_id;
  logic [NL-1:0]   rf_lane_mask;
  logic [VW-1:0]   rf_wdata;
  logic            br_valid;
  logic            br_two_way;
  logic [DW-1:0]   br_target0;
  logic [DW-1:0]   br_target1;
  logic [NL-1:0]   br_mask0;
  logic [NL-1:0]   br_mask1;
  logic            halted;
  logic            err_bad_op;

  store_stage #(.NUM_LANES(NL), .DATA_W(DW), .REG_ID_W(RW), .REG_PC_ID(31)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_exec_mask(in_exec_mask), .in_pc(in_pc), .in_reg_id(in_reg_id),
    .in_vec_a(in_vec_a), .in_vec_b(in_vec_b),
    .in_target0(in_target0), .in_target1(in_target1),
    .in_mask0(in_mask0), .in_mask1(in_mask1),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_reg_id(rf_reg_id), .rf_lane_mask(rf_lane_mask),
    .rf_wdata(rf_wdata),
    .br_valid(br_valid), .br_two_way(br_two_way),
    .br_target0(br_target0), .br_target1(br_target1),
    .br_mask0(br_mask0), .br_mask1(br_mask1),
    .halted(halted), .err_bad_op(err_bad_op)
  );

  typedef struct {
    logic          wr;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    logic [RW-1:0] reg_id;
    logic [NL-1:0] mask;
    logic [VW-1:0] data;
    int            cyc;
  } rf_t;

  typedef struct {
    logic          two;
    logic [DW-1:0] t0;
    logic [DW-1:0] t1;
    logic [NL-1:0] m0;
    logic [NL-1:0] m1;
    int            cyc;
  } br_t;

  req_t exp_req[$];
  req_t obs_req[$];
  rf_t  exp_rf[$];
  rf_t  obs_rf[$];
  br_t  exp_br[$];
  br_t  obs_br[$];
  logic exp_err;
  logic exp_halted;

  int n_checks = 0;
  int n_pass   = 0;
  int ncyc     = 0;

  // responder controls
  int            stall_cnt = 0;
  bit            hold_rsp  = 0;
  bit            rsp_pend  = 0;
  int            rsp_dly   = 0;
  logic [DW-1:0] rsp_data;
  bit            stalled   = 0;
  logic [DW-1:0] st_addr;
  logic [DW-1:0] st_wdata;
  logic          st_write;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [DW-1:0] a);
    return a ^ MEM_KEY;
  endfunction

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  // observe rf writes and redirects
  always @(negedge clk) begin
    if (reset_n) begin
      if (rf_we || br_valid) check("rf_br_exclusive", VW'(rf_we & br_valid), '0);
      if (rf_we) obs_rf.push_back('{rf_reg_id, rf_lane_mask, rf_wdata, ncyc});
      if (br_valid) obs_br.push_back('{br_two_way, br_target0, br_target1, br_mask0, br_mask1, ncyc});
    end
  end

  // memory responder: random ready stalls, random response delay,
  // occasional stray responses when nothing is outstanding
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      stalled       = 0;
    end else begin
      mem_rsp_valid = 1'b0;
      if (rsp_pend && !hold_rsp) begin
        if (rsp_dly == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = rsp_data;
          rsp_pend      = 0;
        end else begin
          rsp_dly--;
        end
      end else if (!rsp_pend && $urandom_range(0, 7) == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {$urandom, $urandom};
      end
      if (stalled) begin
        check("req_held_valid", VW'(mem_req_valid), VW'(1'b1));
        check("req_held_addr", VW'(mem_req_addr), VW'(st_addr));
        check("req_held_wdata", VW'(mem_req_wdata), VW'(st_wdata));
        check("req_held_write", VW'(mem_req_write), VW'(st_write));
      end
      mem_req_ready = 1'b0;
      stalled       = 0;
      if (mem_req_valid) begin
        check("busy_during_mem", VW'(in_ready), '0);
        if (stall_cnt > 0) begin
          stall_cnt--;
          stalled  = 1;
          st_addr  = mem_req_addr;
          st_wdata = mem_req_wdata;
          st_write = mem_req_write;
        end else begin
          mem_req_ready = 1'b1;
          obs_req.push_back('{mem_req_write, mem_req_addr, mem_req_wdata});
          if (!mem_req_write) begin
            rsp_pend = 1;
            rsp_dly  = $urandom_range(0, 3);
            rsp_data = mem_fn(mem_req_addr);
          end
          stall_cnt = $urandom_range(0, 2);
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, VW'(in_ready), VW'(1'b1));
    check({pfx, "_mem_req_valid"}, VW'(mem_req_valid), '0);
    check({pfx, "_mem_req_write"}, VW'(mem_req_write), '0);
    check({pfx, "_mem_req_addr"}, VW'(mem_req_addr), '0);
    check({pfx, "_rf_we"}, VW'(rf_we), '0);
    check({pfx, "_rf_wdata"}, rf_wdata, '0);
    check({pfx, "_br_valid"}, VW'(br_valid), '0);
    check({pfx, "_br_target0"}, VW'(br_target0), '0);
    check({pfx, "_halted"}, VW'(halted), '0);
    check({pfx, "_err_bad_op"}, VW'(err_bad_op), '0);
  endtask

  task automatic compare_queues();
    req_t eq, oq;
    rf_t  er, orr;
    br_t  eb, ob;
    check("req_count", VW'(obs_req.size()), VW'(exp_req.size()));
    while (exp_req.size() > 0 && obs_req.size() > 0) begin
      eq = exp_req.pop_front();
      oq = obs_req.pop_front();
      check("req_write", VW'(oq.wr), VW'(eq.wr));
      check("req_addr", VW'(oq.addr), VW'(eq.addr));
      if (eq.wr) check("req_wdata", VW'(oq.data), VW'(eq.data));
    end
    check("rf_count", VW'(obs_rf.size()), VW'(exp_rf.size()));
    while (exp_rf.size() > 0 && obs_rf.size() > 0) begin
      er  = exp_rf.pop_front();
      orr = obs_rf.pop_front();
      check("rf_reg_id", VW'(orr.reg_id), VW'(er.reg_id));
      check("rf_lane_mask", VW'(orr.mask), VW'(er.mask));
      check("rf_wdata", orr.data, er.data);
      if (er.cyc >= 0) check("rf_latency", VW'(orr.cyc), VW'(er.cyc));
    end
    check("br_count", VW'(obs_br.size()), VW'(exp_br.size()));
    while (exp_br.size() > 0 && obs_br.size() > 0) begin
      eb = exp_br.pop_front();
      ob = obs_br.pop_front();
      check("br_two_way", VW'(ob.two), VW'(eb.two));
      check("br_target0", VW'(ob.t0), VW'(eb.t0));
      check("br_mask0", VW'(ob.m0), VW'(eb.m0));
      if (eb.two) begin
        check("br_target1", VW'(ob.t1), VW'(eb.t1));
        check("br_mask1", VW'(ob.m1), VW'(eb.m1));
      end
      if (eb.cyc >= 0) check("br_latency", VW'(ob.cyc), VW'(eb.cyc));
    end
    exp_req.delete(); obs_req.delete();
    exp_rf.delete();  obs_rf.delete();
    exp_br.delete();  obs_br.delete();
    check("err_bad_op", VW'(err_bad_op), VW'(exp_err));
    check("halted", VW'(halted), VW'(exp_halted));
  endtask

  // drive one packet, record what it must do architecturally, then wait
  // for the stage to go idle and compare
  task automatic send_pkt(input logic [2:0] op, input logic [NL-1:0] mask,
                          input logic [RW-1:0] rid, input logic [VW-1:0] va,
                          input logic [VW-1:0] vb, input logic [DW-1:0] t0,
                          input logic [DW-1:0] t1, input logic [NL-1:0] m0,
                          input logic [NL-1:0] m1);
    bit            ok;
    int            acc;
    logic [VW-1:0] ld;
    int            low;
    wait_ready(ok);
    check("accept_timeout", VW'(ok), VW'(1'b1));
    if (!ok) return;
    in_op        = op;
    in_exec_mask = mask;
    in_reg_id    = rid;
    in_vec_a     = va;
    in_vec_b     = vb;
    in_target0   = t0;
    in_target1   = t1;
    in_mask0     = m0;
    in_mask1     = m1;
    in_pc        = {$urandom, $urandom};
    in_valid     = 1'b1;
    acc          = ncyc;
    case (op)
      3'd0: exp_halted = 1'b1;
      3'd1: exp_br.push_back('{1'b0, t0, '0, mask, '0, acc + 1});
      3'd2: exp_br.push_back('{1'b1, t0, t1, m0, m1, acc + 1});
      3'd3: begin
        ld  = '0;
        low = -1;
        for (int i = 0; i < NL; i++) begin
          if (mask[i]) begin
            exp_req.push_back('{1'b0, va[i*DW +: DW], '0});
            ld[i*DW +: DW] = mem_fn(va[i*DW +: DW]);
            if (low < 0) low = i;
          end
        end
        if (low >= 0) begin
          if (rid == 5'd31) exp_br.push_back('{1'b0, ld[low*DW +: DW], '0, mask, '0, -1});
          else exp_rf.push_back('{rid, mask, ld, -1});
        end
      end
      3'd4: begin
        for (int i = 0; i < NL; i++)
          if (mask[i]) exp_req.push_back('{1'b1, va[i*DW +: DW], vb[i*DW +: DW]});
      end
      3'd5: if (mask != '0) exp_rf.push_back('{rid, mask, va, acc + 1});
      default: exp_err = 1'b1;
    endcase
    @(negedge clk);
    in_valid = 1'b0;
    if (op == 3'd0) begin
      check("halt_halted", VW'(halted), VW'(1'b1));
      check("halt_in_ready", VW'(in_ready), '0);
      return;
    end
    wait_ready(ok);
    check("done_timeout", VW'(ok), VW'(1'b1));
    compare_queues();
  endtask

  logic [VW-1:0] va, vb;
  logic [2:0]    rop;
  logic [RW-1:0] rrid;
  int            r;
  bit            ok;

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_op        = '0;
    in_exec_mask = '0;
    in_pc        = '0;
    in_reg_id    = '0;
    in_vec_a     = '0;
    in_vec_b     = '0;
    in_target0   = '0;
    in_target1   = '0;
    in_mask0     = '0;
    in_mask1     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    exp_err      = 1'b0;
    exp_halted   = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", VW'(in_ready), VW'(1'b1));

    // register write from vector, lanes {1,2,3,4}
    va = {64'd4, 64'd3, 64'd2, 64'd1};
    send_pkt(3'd5, 4'b1010, 5'd3, va, '0, '0, '0, '0, '0);

    // two stores with a stalled first lane
    va = rvec();
    vb = rvec();
    va[0*DW +: DW] = 64'h100;
    va[2*DW +: DW] = 64'h300;
    vb[0*DW +: DW] = 64'hA;
    vb[2*DW +: DW] = 64'hC;
    stall_cnt = 2;
    send_pkt(3'd4, 4'b0101, 5'd0, va, vb, '0, '0, '0, '0);

    // full-width load with random response delays
    send_pkt(3'd3, 4'b1111, 5'd7, rvec(), rvec(), '0, '0, '0, '0);

    // load into PC: lane 1 returns 0x40
    va = rvec();
    va[1*DW +: DW] = 64'h40 ^ MEM_KEY;
    send_pkt(3'd3, 4'b0110, 5'd31, va, '0, '0, '0, '0, '0);

    // empty masks and a bad opcode
    send_pkt(3'd5, 4'b0000, 5'd4, rvec(), '0, '0, '0, '0, '0);
    send_pkt(3'd4, 4'b0000, 5'd4, rvec(), rvec(), '0, '0, '0, '0);
    send_pkt(3'd3, 4'b0000, 5'd4, rvec(), rvec(), '0, '0, '0, '0);
    send_pkt(3'd1, 4'b0000, 5'd0, '0, '0, 64'h1234, '0, '0, '0);
    send_pkt(3'd6, 4'b1111, 5'd2, rvec(), '0, '0, '0, '0, '0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 19);
      if (r < 5)       rop = 3'd3;
      else if (r < 10) rop = 3'd4;
      else if (r < 14) rop = 3'd5;
      else if (r < 16) rop = 3'd1;
      else if (r < 18) rop = 3'd2;
      else if (r < 19) rop = 3'd6;
      else             rop = 3'd7;
      rrid = 5'($urandom_range(0, 31));
      if (rop == 3'd3) rrid = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      send_pkt(rop, 4'($urandom_range(0, 15)), rrid, rvec(), rvec(),
               {$urandom, $urandom}, {$urandom, $urandom},
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // reset while a load is waiting for its response
    hold_rsp = 1;
    wait_ready(ok);
    check("mid_reset_accept", VW'(ok), VW'(1'b1));
    in_op        = 3'd3;
    in_exec_mask = 4'b1111;
    in_reg_id    = 5'd9;
    in_vec_a     = rvec();
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (obs_req.size() > 0) begin
        ok = 1;
        break;
      end
    end
    check("mid_reset_first_req", VW'(ok), VW'(1'b1));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_req.delete(); obs_req.delete();
    exp_rf.delete();  obs_rf.delete();
    exp_br.delete();  obs_br.delete();
    exp_err    = 1'b0;
    exp_halted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    hold_rsp = 0;
    repeat (6) @(negedge clk);
    check("late_rsp_no_rf", VW'(obs_rf.size()), '0);
    check("late_rsp_no_br", VW'(obs_br.size()), '0);
    check("late_rsp_no_req", VW'(obs_req.size()), '0);
    check("late_rsp_in_ready", VW'(in_ready), VW'(1'b1));

    // divergent branch then halt
    send_pkt(3'd2, 4'b1111, 5'd0, '0, '0, 64'h80, 64'h44, 4'b0011, 4'b1100);
    send_pkt(3'd0, 4'b1111, 5'd0, '0, '0, '0, '0, '0, '0);
    in_op        = 3'd5;
    in_exec_mask = 4'b1111;
    in_reg_id    = 5'd1;
    in_vec_a     = rvec();
    in_valid     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halted_in_ready", VW'(in_ready), '0);
      check("halted_sticky", VW'(halted), VW'(1'b1));
    end
    in_valid = 1'b0;
    check("halted_no_rf", VW'(obs_rf.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_stage.md
Name: store_stage

Overview:
- Final pipeline stage; sits directly downstream of the execute stage and consumes its storage packets.
- Performs the architectural side effects of each packet: register-file writes, per-lane memory loads and stores, fetch redirects for jumps and conditional jumps, and halt.
- Memory accesses are serialized one active lane at a time, with one outstanding request.

Parameters:
- NUM_LANES, 4, SIMT lanes per vector (width of exec masks)
- DATA_W, 64, lane data and address width
- REG_ID_W, 5, register identifier width
- REG_PC_ID, 31, register ID that denotes the program counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  packet from execute stage valid
- in_ready  out  1  stage can accept packet (execute stage's "not busy")
- in_op  in  3  0=HALT 1=JMP 2=CJMP 3=LOAD_MEM_INTO_REG 4=STORE_REG_INTO_MEM 5=STORE_VALUE_INTO_REG
- in_exec_mask  in  NUM_LANES  active lanes
- in_pc  in  DATA_W  PC of instruction
- in_reg_id  in  REG_ID_W  destination register
- in_vec_a  in  NUM_LANES*DATA_W  addresses (op 3,4) or values (op 5); lane i at bits [i*DATA_W +: DATA_W]
- in_vec_b  in  NUM_LANES*DATA_W  store data (op 4)
- in_target0  in  DATA_W  jump target (JMP) / taken target (CJMP)
- in_target1  in  DATA_W  fall-through target (CJMP)
- in_mask0  in  NUM_LANES  taken-lane mask (CJMP)
- in_mask1  in  NUM_LANES  fall-through mask (CJMP)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1=store, 0=load
- mem_req_addr  out  DATA_W  lane address
- mem_req_wdata  out  DATA_W  lane store data
- mem_rsp_valid  in  1  load data returned
- mem_rsp_data  in  DATA_W  load data
- rf_we  out  1  register write strobe (also marks register valid)
- rf_reg_id  out  REG_ID_W  register written
- rf_lane_mask  out  NUM_LANES  lanes written
- rf_wdata  out  NUM_LANES*DATA_W  write data
- br_valid  out  1  fetch redirect pulse
- br_two_way  out  1  redirect is a divergent CJMP
- br_target0, br_target1  out  DATA_W  redirect targets
- br_mask0, br_mask1  out  NUM_LANES  lane masks per target
- halted  out  1  sticky halt indication
- err_bad_op  out  1  sticky: unknown opcode received

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; all outputs 0 except in_ready=1; load buffer cleared. Reset mid-operation abandons any in-flight lane; a memory response arriving after reset is ignored.
- States: IDLE, MEM_REQ, MEM_WAIT, WRITEBACK, HALTED.
- in_ready = (state==IDLE). A packet is accepted on in_valid&&in_ready and captured into a packet register.
- HALT: → HALTED on the next cycle. halted=1, in_ready=0 until reset.
- JMP: next cycle br_valid=1, br_target0=in_target0, br_mask0=in_exec_mask, br_two_way=0. Stay IDLE.
- CJMP: next cycle br_valid=1, br_two_way=1, targets and masks as received.
- STORE_VALUE_INTO_REG: next cycle rf_we=1, rf_reg_id, rf_lane_mask=exec_mask, rf_wdata=in_vec_a. Total latency is 1 cycle.
- STORE_REG_INTO_MEM: → MEM_REQ. Lanes are visited lowest index first, active lanes only.
  - Drive mem_req_valid=1, write=1, addr and wdata of the current lane, held stable until mem_req_ready.
  - On handshake, advance to the next active lane. After the last lane, → IDLE. No rf write.
- LOAD_MEM_INTO_REG: per active lane, MEM_REQ (write=0) then MEM_WAIT until mem_rsp_valid.
  - Store mem_rsp_data into that lane of the buffer.
  - After the last lane, → WRITEBACK: rf_we=1 for one cycle with mask=exec_mask and inactive lanes 0, then → IDLE.
  - If reg_id==REG_PC_ID, instead emit br_valid with target0 = the value of the lowest active lane, mask0=exec_mask, and no rf_we.
- Zero exec_mask with op 3/4/5: retire in one cycle with no mem or rf activity; returns to IDLE.
- Zero exec_mask with JMP/CJMP: a redirect is still emitted.
- rf_we and br_valid are single-cycle pulses and never both high in the same cycle.
- mem_rsp_valid outside MEM_WAIT is ignored.
- Unknown opcode (6, 7): err_bad_op=1 sticky; packet dropped; stays IDLE.

Test Plan:
- Reset with reset_n low mid-load (state MEM_WAIT) → all outputs 0, in_ready=1 next cycle; a late mem_rsp_valid produces no rf_we.
- op5, reg 3, mask 0b1010, vec_a lanes {1,2,3,4} → one cycle later rf_we=1, reg_id 3, mask 0b1010, wdata {1,2,3,4}.
- op4, mask 0b0101, addr {0x100,x,0x300,x}, data {0xA,x,0xC,x}, mem_req_ready stalled 2 cycles on the first lane → exactly two stores in order (0x100,0xA) then (0x300,0xC); in_ready=0 throughout; address held stable during the stall.
- op3, mask 0b1111, responses returned with variable delay → four reads, lane order 0..3; a single rf_we with mask 0b1111 and the correct data per lane.
- op3 with reg_id=31, mask 0b0110, lane1 data 0x40 → br_valid, target0=0x40, mask0=0b0110, no rf_we.
- CJMP target0=0x80, target1=0x44, masks 0b0011/0b1100 → br_valid, br_two_way=1, values echoed. Then HALT → halted=1, in_ready stays 0.
